// File: rtl/masked_word_fifo.sv
// -----------------------------------------------------------------------------
// masked_word_fifo
//
// Small first-word-fall-through FIFO that sits behind the 32-bit registered
// word stage. Each accepted word is ANDed with a per-write mask before it is
// stored. Buffered words are presented to the next consumer over valid/ready.
// A word offered while the FIFO is full is dropped and flagged in a sticky
// overflow bit.
//
// Ports:
//   clock      in   single clock, all state updates on posedge
//   reset_n    in   synchronous active-low reset, highest priority
//   in_data    in   [WIDTH]  word from the upstream register stage
//   in_valid   in   in_data is valid this cycle
//   in_ready   out  FIFO can accept a word this cycle (count != DEPTH)
//   mask       in   [WIDTH]  AND mask applied to in_data at write time
//   out_data   out  [WIDTH]  head entry, 0 when empty
//   out_valid  out  head entry present (count != 0)
//   out_ready  in   consumer takes the head this cycle
//   count      out  [CNT_W]  entries held, 0..DEPTH
//   overflow   out  sticky: at least one word was dropped
//   clear_ovf  in   clears overflow (a same-cycle drop wins)
//
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module masked_word_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] mask,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] count,
   output logic             overflow,
   input  logic             clear_ovf
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_overflow;

   logic [PTR_W-1:0] w_wr_ptr_d;
   logic [PTR_W-1:0] w_rd_ptr_d;
   logic [CNT_W-1:0] w_count_d;
   logic             w_overflow_d;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;
   logic w_drop;

   // Status derived from registered state only, so out_ready never reaches
   // in_ready: a pop while full frees a slot for the next cycle, not this one.
   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_empty = (r_count == '0);

   assign w_push = in_valid && !w_full;
   assign w_pop  = !w_empty && out_ready;
   assign w_drop = in_valid && w_full;

   always_comb begin
      w_wr_ptr_d   = r_wr_ptr;
      w_rd_ptr_d   = r_rd_ptr;
      w_count_d    = r_count;
      w_overflow_d = r_overflow;

      if (w_push) begin
         w_wr_ptr_d = r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
         w_rd_ptr_d = r_rd_ptr + PTR_W'(1);
      end

      unique case ({w_push, w_pop})
         2'b10:   w_count_d = r_count + CNT_W'(1);
         2'b01:   w_count_d = r_count - CNT_W'(1);
         default: w_count_d = r_count;
      endcase

      // Set has priority over clear so a drop is never lost.
      if (w_drop) begin
         w_overflow_d = 1'b1;
      end else if (clear_ovf) begin
         w_overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_wr_ptr   <= w_wr_ptr_d;
         r_rd_ptr   <= w_rd_ptr_d;
         r_count    <= w_count_d;
         r_overflow <= w_overflow_d;
      end
   end

   // Storage is not reset; the pointers alone define which entries are live.
   always_ff @(posedge clock) begin
      if (reset_n && w_push) begin
         r_mem[r_wr_ptr] <= in_data & mask;
      end
   end

   assign in_ready  = !w_full;
   assign out_valid = !w_empty;
   assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
   assign count     = r_count;
   assign overflow  = r_overflow;

endmodule

// File: doc/masked_word_fifo.md
Name: masked_word_fifo

Overview:
- Downstream consumer of the 32-bit registered word stage.
- Captures each accepted word, ANDs it with a per-write mask, and buffers it in a small first-word-fall-through FIFO.
- Presents buffered words to the next consumer over a valid/ready handshake.
- Flags dropped words with a sticky overflow bit.

Parameters:
- WIDTH, 32: data word width in bits.
- DEPTH, 4: number of entries; must be a power of 2 and >= 2.
- CNT_W, $clog2(DEPTH)+1: width of the occupancy count.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset_n  input  1  synchronous, active-low reset, sampled on posedge clock.
- in_data  input  WIDTH  word from the upstream register stage.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  FIFO can accept a word this cycle.
- mask  input  WIDTH  AND mask applied to in_data at write time.
- out_data  output  WIDTH  head entry.
- out_valid  output  1  head entry present.
- out_ready  input  1  consumer takes the head this cycle.
- count  output  CNT_W  number of entries held, 0..DEPTH.
- overflow  output  1  sticky: at least one word was dropped.
- clear_ovf  input  1  clears overflow.

Behaviour:
- Clock/reset: one clock, `clock`. Reset is synchronous and active-low on `reset_n`.
- Reset (reset_n=0 at posedge):
  - Read and write pointers go to 0; count=0; overflow=0.
  - Any buffered contents are discarded, including on reset mid-operation.
  - Memory array is not reset.
  - reset_n has priority over every other input.
- Outputs after reset: in_ready=1, out_valid=0, out_data=0, count=0, overflow=0.
- in_ready = (count != DEPTH).
  - Combinational from state only.
  - No combinational path from out_ready to in_ready: when full, a same-cycle pop does not allow a push.
- Push:
  - Occurs when in_valid && in_ready at posedge.
  - mem[wr_ptr] <= in_data & mask; wr_ptr increments modulo DEPTH, wrapping DEPTH-1 -> 0.
- Pop:
  - Occurs when out_valid && out_ready at posedge.
  - rd_ptr increments modulo DEPTH.
  - out_ready while out_valid=0 has no effect.
- out_valid = (count != 0).
- out_data = mem[rd_ptr] when out_valid=1, else 0. Combinational read (first-word fall-through).
- Latency: a word pushed at posedge N appears on out_data/out_valid after that edge, i.e. it is poppable at posedge N+1 at the earliest.
- count update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle (only possible when 0 < count < DEPTH): unchanged.
  - Never exceeds DEPTH; never underflows.
- Empty: a push with out_ready=1 is not a pop; the word becomes visible next cycle.
- Overflow:
  - in_valid && !in_ready at posedge sets overflow=1; the word is dropped.
  - Pointers and count are unchanged by the dropped word.
  - clear_ovf=1 clears overflow.
  - If set and clear occur in the same cycle, set wins (overflow=1).
- Ordering: strict FIFO; no reordering or duplication across pointer wrap-around.

Test Plan:
- Reset state: hold reset_n=0 for 2 cycles, then release -> count=0, in_ready=1, out_valid=0, out_data=0, overflow=0.
- Masked push:
  - Push in_data=32'h12345678 with mask=32'hFFFF0000, out_ready=0 -> next cycle out_valid=1, out_data=32'h12340000, count=1.
  - Pop with out_ready=1 -> count=0, out_valid=0, out_data=0.
- Fill and overflow:
  - Push 32'h55555555 four times with mask=32'hFFFFFFFF -> count=4, in_ready=0.
  - Fifth push of 32'hAAAAAAAA -> dropped, overflow=1, count=4.
  - Drain -> four outputs of 32'h55555555.
  - clear_ovf=1 -> overflow=0.
- Simultaneous push/pop and wrap:
  - Preload 2 words (1, 2).
  - Then for 6 cycles push 3..8 while popping, with mask all-ones -> count stays 2; outputs 1..6 in order across pointer wrap.
- Full with pop:
  - count=4, in_valid=1, out_ready=1 same cycle -> only the pop occurs; count=3; overflow=1 (push refused); in_ready=1 next cycle.
- Reset mid-operation:
  - count=3; assert reset_n=0 for 1 cycle while in_valid=1 -> count=0, out_valid=0, overflow=0; the in-flight word is not stored.
